alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among NUM_REQ requesters.
// One operation is in flight at a time; a WAIT timeout turns a hung ALU into an error response.
package warp_pkg;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_MUL = 4'd5,
        ALU_FMA = 4'd6,
        ALU_NOP = 4'd15
    } alu_opcode_e;
endpackage

module alu_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = warp_pkg::DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  warp_pkg::alu_opcode_e [NUM_REQ-1:0]   req_opcode,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_op1,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_op2,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_op3,
    output warp_pkg::alu_opcode_e                 alu_opcode,
    output logic [DATA_WIDTH-1:0]                 alu_operand1,
    output logic [DATA_WIDTH-1:0]                 alu_operand2,
    output logic [DATA_WIDTH-1:0]                 alu_operand3,
    output logic                                  alu_start,
    input  logic                                  alu_ready,
    input  logic [DATA_WIDTH-1:0]                 alu_result,
    input  logic                                  alu_overflow,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]                 rsp_result,
    output logic                                  rsp_overflow,
    output logic                                  rsp_error,
    output logic                                  busy
);
    localparam int unsigned ID_W    = $clog2(NUM_REQ);
    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_idx;
    logic              w_any;
    logic              w_accept;
    logic              w_expire;
    logic [CNT_W-1:0]  r_cnt;

    // Round-robin search starting at r_ptr, wrapping modulo NUM_REQ
    always_comb begin : rr_pick
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
        w_ptr_nxt = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);
    end

    assign w_accept = (r_state == S_IDLE) && w_any;
    assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_W'(TO_LAST));

    // Next-state and combinational grant
    always_comb begin : fsm_next
        w_state_nxt = r_state;
        req_ready   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_ISSUE;
                    if (rst) begin
                        req_ready[w_winner] = 1'b1;
                    end
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (alu_ready || w_expire) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; status outputs are registered from the next state
    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            alu_start <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            alu_start <= (w_state_nxt == S_ISSUE);
            rsp_valid <= (w_state_nxt == S_RESP);
            busy      <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
            end
            r_cnt <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
        end
    end

    // Operation latch at accept; ALU completion wins over a same-cycle timeout
    always_ff @(posedge clk or negedge rst) begin : data_reg
        if (!rst) begin
            alu_opcode   <= warp_pkg::ALU_ADD;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_operand3 <= '0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_opcode   <= req_opcode[w_winner];
                alu_operand1 <= req_op1[w_winner];
                alu_operand2 <= req_op2[w_winner];
                alu_operand3 <= req_op3[w_winner];
                rsp_id       <= w_winner;
            end
            if (r_state == S_WAIT) begin
                if (alu_ready) begin
                    rsp_result   <= alu_result;
                    rsp_overflow <= alu_overflow;
                    rsp_error    <= 1'b0;
                end else if (w_expire) begin
                    rsp_result   <= '0;
                    rsp_overflow <= 1'b0;
                    rsp_error    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration order, ALU handshake, timeout,
// backpressure and reset behaviour, checked with immediate assertions.
module tb_alu_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 4;

    logic                                clk;
    logic                                rst;
    logic [NREQ-1:0]                     req_valid;
    logic [NREQ-1:0]                     req_ready;
    warp_pkg::alu_opcode_e [NREQ-1:0]    req_opcode;
    logic [NREQ-1:0][DW-1:0]             req_op1;
    logic [NREQ-1:0][DW-1:0]             req_op2;
    logic [NREQ-1:0][DW-1:0]             req_op3;
    warp_pkg::alu_opcode_e               alu_opcode;
    logic [DW-1:0]                       alu_operand1;
    logic [DW-1:0]                       alu_operand2;
    logic [DW-1:0]                       alu_operand3;
    logic                                alu_start;
    logic                                alu_ready;
    logic [DW-1:0]                       alu_result;
    logic                                alu_overflow;
    logic                                rsp_valid;
    logic                                rsp_ready;
    logic [1:0]                          rsp_id;
    logic [DW-1:0]                       rsp_result;
    logic                                rsp_overflow;
    logic                                rsp_error;
    logic                                busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_op1(req_op1), .req_op2(req_op2), .req_op3(req_op3),
        .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
        .alu_operand2(alu_operand2), .alu_operand3(alu_operand3),
        .alu_start(alu_start), .alu_ready(alu_ready),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_error(rsp_error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; caller has set req_valid while the DUT is IDLE.
    // ready_at = WAIT cycle in which alu_ready is raised (0 = never).
    task automatic run_op(input string tag, input int exp_id, input int ready_at,
                          input logic [31:0] res, input logic ovf, input int hold);
        int n;
        int exp_waits;
        logic exp_err;
        exp_err   = (ready_at == 0);
        exp_waits = exp_err ? int'(TO) : ready_at;
        #1;
        chk({tag, "_grant"}, 64'(req_ready), 64'(4'b0001 << exp_id));
        @(posedge clk); #1;
        chk({tag, "_start"}, 64'(alu_start), 64'd1);
        chk({tag, "_op1"}, 64'(alu_operand1), 64'(req_op1[exp_id]));
        chk({tag, "_opc"}, 64'(alu_opcode), 64'(req_opcode[exp_id]));
        alu_ready = 1'b1;
        @(posedge clk); #1;
        alu_ready = 1'b0;
        chk({tag, "_start_off"}, 64'(alu_start), 64'd0);
        n = 1;
        while (!rsp_valid && n <= 20) begin
            alu_ready    = (n == ready_at);
            alu_result   = res;
            alu_overflow = ovf;
            @(posedge clk); #1;
            alu_ready = 1'b0;
            n++;
        end
        chk({tag, "_rspv"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_waits"}, 64'(n - 1), 64'(exp_waits));
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_v"}, 64'(rsp_valid), 64'd1);
            chk({tag, "_hold_rr"}, 64'(req_ready), 64'd0);
            chk({tag, "_hold_res"}, 64'(rsp_result), 64'(exp_err ? 32'd0 : res));
            alu_result = ~res;
            @(posedge clk); #1;
        end
        chk({tag, "_id"}, 64'(rsp_id), 64'(exp_id));
        chk({tag, "_res"}, 64'(rsp_result), 64'(exp_err ? 32'd0 : res));
        chk({tag, "_ovf"}, 64'(rsp_overflow), 64'(exp_err ? 1'b0 : ovf));
        chk({tag, "_err"}, 64'(rsp_error), 64'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_rspv"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        alu_ready    = 1'b0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        rsp_ready    = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_opcode[i] = (i % 2 == 0) ? warp_pkg::ALU_ADD : warp_pkg::ALU_SUB;
            req_op1[i]    = 32'(16 * i + 3);
            req_op2[i]    = 32'(i + 100);
            req_op3[i]    = 32'(i);
        end
        #2 rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_alu_start", 64'(alu_start), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Fairness with all requesters asserted; first grant after reset is 0
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("fair%0d", i), i % 4, 1, 32'(200 + i), 1'b0, 0);
        end

        // Wrap after a grant to 3, skipping idle requesters
        req_valid = 4'b0110;
        run_op("skip1", 1, 1, 32'h11, 1'b0, 0);
        run_op("skip2", 2, 1, 32'h22, 1'b1, 0);

        // Single request ADD 5+7, ALU replies in the second WAIT cycle
        req_valid     = 4'b0100;
        req_opcode[2] = warp_pkg::ALU_ADD;
        req_op1[2]    = 32'd5;
        req_op2[2]    = 32'd7;
        run_op("single", 2, 2, 32'd12, 1'b0, 0);
        chk("single_op2", 64'(alu_operand2), 64'd7);

        // Timeout with alu_ready never raised
        req_valid = 4'b0001;
        run_op("timeout", 0, 0, 32'hDEAD, 1'b1, 0);

        // Completion and timeout expiry in the same cycle: completion wins
        req_valid = 4'b0010;
        run_op("race", 1, int'(TO), 32'h5A5A, 1'b1, 0);

        // Response backpressure for 5 cycles with requests pending
        req_valid = 4'b1000;
        run_op("bp", 3, 1, 32'hCAFE, 1'b0, 5);

        // Reset in the middle of WAIT
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_start", 64'(alu_start), 64'd0);
        chk("mid_rst_rspv", 64'(rsp_valid), 64'd0);
        chk("mid_rst_op1", 64'(alu_operand1), 64'd0);
        chk("mid_rst_res", 64'(rsp_result), 64'd0);
        @(posedge clk); #1;
        rst       = 1'b1;
        alu_ready = 1'b1;
        @(posedge clk); #1;
        alu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_rspv", 64'(rsp_valid), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 4'b1000;
        run_op("post_rst", 3, 1, 32'h77, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
